piso_tx_scheduler: RTL and testbench

- Round-robin scheduler that shares one 4-bit parallel-in/serial-out shift register among NREQ requesters.
- Each requester offers a WIDTH-bit nibble. The block picks a winner, drives the shifter's active-low load strobe and parallel data, times the WIDTH shift cycles, and inserts an idle gap between frames.
- Sits between the nibble producers and the serializer. The serializer shifts LSB first, fills with 1s, and its serial output idles high.

---
 rtl/piso_tx_scheduler_pkg.sv | 15 +
 rtl/rr_arbiter_pick.sv | 30 +++
 rtl/piso_tx_scheduler.sv | 106 ++++++++++
 tb/tb_piso_tx_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_scheduler_pkg.sv
// Shared types and constants for the PISO transmit scheduler and its helpers.
// The serializer is external; only its idle line level is recorded here.
package piso_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam int   DEFAULT_WIDTH = 4;
    localparam logic IDLE_LEVEL    = 1'b1;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
// Shared by the controllers that time-multiplex a single resource.
module rr_arbiter_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] rr_ptr,
    output logic [IDXW-1:0] winner,
    output logic            any_req
);

    always_comb begin
        int   idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                winner = IDXW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler feeding one external parallel-in/serial-out shifter:
// picks a requester, strobes the load, times the shift window and the idle gap.
module piso_tx_scheduler
    import piso_tx_scheduler_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GAP   = 1,
    parameter int IDXW  = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          grant,
    output logic                     piso_load_n,
    output logic [WIDTH-1:0]         piso_data,
    output logic                     tx_active,
    output logic [IDXW-1:0]          tx_src,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     busy
);

    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0]   GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [IDXW-1:0] SRC_LAST = IDXW'(NREQ - 1);

    state_t           state, state_nxt;
    logic [IDXW-1:0]  rr_ptr;
    logic [IDXW-1:0]  winner;
    logic             any_req;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [WIDTH-1:0] win_data;

    rr_arbiter_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb win_data = req_data[int'(winner) * WIDTH +: WIDTH];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_SHIFT;
            S_SHIFT: if (bit_cnt == BIT_LAST) state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
            S_GAP:   if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Data is captured on IDLE exit, so later req_data changes never reach the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            tx_src    <= '0;
            piso_data <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        tx_src    <= winner;
                        piso_data <= win_data;
                    end
                end
                S_LOAD: begin
                    rr_ptr  <= (tx_src == SRC_LAST) ? '0 : tx_src + 1'b1;
                    bit_cnt <= '0;
                end
                S_SHIFT: begin
                    if (bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + 1'b1;
                    gap_cnt <= '0;
                end
                S_GAP: begin
                    if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from state only, so an async reset drops them immediately.
    always_comb begin
        grant = '0;
        if (state == S_LOAD) grant[tx_src] = 1'b1;
    end

    assign piso_load_n = (state != S_LOAD);
    assign tx_active   = (state == S_SHIFT);
    assign busy        = (state != S_IDLE);
    assign bit_idx     = bit_cnt;

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Directed bench for piso_tx_scheduler with a behavioural LSB-first serializer
// on the main instance and a second GAP=0 instance sharing the same inputs.
module tb_piso_tx_scheduler;
    import piso_tx_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] req_data = '0;

    logic [3:0]  grant, g0_grant;
    logic        piso_load_n, g0_piso_load_n;
    logic [3:0]  piso_data, g0_piso_data;
    logic        tx_active, g0_tx_active;
    logic [1:0]  tx_src, g0_tx_src;
    logic [1:0]  bit_idx, g0_bit_idx;
    logic        busy, g0_busy;

    piso_tx_scheduler #(.NREQ(4), .WIDTH(4), .GAP(1)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .piso_load_n(piso_load_n), .piso_data(piso_data),
        .tx_active(tx_active), .tx_src(tx_src), .bit_idx(bit_idx), .busy(busy)
    );

    piso_tx_scheduler #(.NREQ(4), .WIDTH(4), .GAP(0)) dut0 (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(g0_grant), .piso_load_n(g0_piso_load_n), .piso_data(g0_piso_data),
        .tx_active(g0_tx_active), .tx_src(g0_tx_src), .bit_idx(g0_bit_idx), .busy(g0_busy)
    );

    always #5 clk = ~clk;

    // Serializer model: load when piso_load_n=0, otherwise shift right filling with idle level.
    logic [3:0] sr = 4'hF;
    logic       line;
    always @(posedge clk) begin
        if (!piso_load_n) sr <= piso_data;
        else              sr <= {IDLE_LEVEL, sr[3:1]};
    end
    assign line = sr[0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] data;
        logic [3:0]  grant;
        logic        load_n;
        logic        txa;
        logic        busy;
        logic        line;
        logic [1:0]  bidx;
        logic [1:0]  src;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
    endtask

    task automatic wait_grant(output logic [3:0] g, output int t);
        g = '0;
        t = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (grant != 0) begin
                g = grant;
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_grant: no grant within 40 cycles, required a grant");
        end
    endtask

    initial begin
        logic [3:0] g;
        int         t, tprev, nspur, n0, t0a, t0b, tdut;
        logic [3:0] g0a, g0b, gdut;

        // req, data, grant, load_n, txa, busy, line, bidx, src
        tbl[0]  = '{4'b0001, 16'h000A, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tbl[1]  = '{4'b0000, 16'h000A, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0};
        tbl[2]  = '{4'b0000, 16'h000A, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0};
        tbl[3]  = '{4'b0000, 16'h000A, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 2'd0};
        tbl[4]  = '{4'b0000, 16'h000A, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 2'd0};
        tbl[5]  = '{4'b0000, 16'h000A, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
        tbl[6]  = '{4'b0000, 16'h000A, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0};
        tbl[7]  = '{4'b0100, 16'h0F00, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd2};
        tbl[8]  = '{4'b0000, 16'h0F00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd2};
        tbl[9]  = '{4'b0000, 16'h0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 2'd2};
        tbl[10] = '{4'b0000, 16'h0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 2'd2};
        tbl[11] = '{4'b0000, 16'h0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 2'd2};
        tbl[12] = '{4'b0000, 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd2};
        tbl[13] = '{4'b0000, 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0};

        // Reset state
        repeat (2) tick();
        chk("rst_grant", grant, 4'b0000);
        chk("rst_load_n", piso_load_n, 1'b1);
        chk("rst_piso_data", piso_data, 4'h0);
        chk("rst_tx_active", tx_active, 1'b0);
        chk("rst_tx_src", tx_src, 2'd0);
        chk("rst_bit_idx", bit_idx, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_busy_gap0", g0_busy, 1'b0);
        reset = 1'b0;
        tick();

        // Single request frame, then a frame whose data changes after grant
        for (int i = 0; i < 14; i++) begin
            req      = tbl[i].req;
            req_data = tbl[i].data;
            tick();
            chk($sformatf("vec%0d_grant", i), grant, tbl[i].grant);
            chk($sformatf("vec%0d_load_n", i), piso_load_n, tbl[i].load_n);
            chk($sformatf("vec%0d_tx_active", i), tx_active, tbl[i].txa);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("vec%0d_line", i), line, tbl[i].line);
            if (tbl[i].txa) chk($sformatf("vec%0d_bit_idx", i), bit_idx, tbl[i].bidx);
            if (tbl[i].busy) chk($sformatf("vec%0d_tx_src", i), tx_src, tbl[i].src);
        end

        // All requesting: strict rotation, one grant every 7 cycles
        do_reset();
        req      = 4'b1111;
        req_data = 16'h4321;
        tprev    = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g, t);
            chk($sformatf("all_grant%0d", k), g, 4'b0001 << (k % 4));
            chk($sformatf("all_src%0d", k), tx_src, k % 4);
            chk($sformatf("all_data%0d", k), piso_data, (k % 4) + 1);
            if (k > 0) chk($sformatf("all_spacing%0d", k), t - tprev, 7);
            tprev = t;
        end
        req = '0;

        // Pointer skip: after serving 0, requester 3 wins before 0
        do_reset();
        req = 4'b0001;
        wait_grant(g, t);
        chk("skip_first", g, 4'b0001);
        req = 4'b1001;
        wait_grant(g, t);
        chk("skip_second", g, 4'b1000);
        wait_grant(g, t);
        chk("skip_third", g, 4'b0001);
        req = '0;

        // Request withdrawn during another frame's SHIFT is never served
        do_reset();
        req = 4'b0001;
        wait_grant(g, t);
        req = '0;
        tick();
        tick();
        req = 4'b0100;
        tick();
        req = '0;
        nspur = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant != 0) nspur++;
        end
        chk("withdraw_no_grant", nspur, 0);
        chk("withdraw_idle", busy, 1'b0);

        // Async reset mid-SHIFT at bit_idx=2, then rr_ptr must be back at 0
        do_reset();
        req = 4'b0010;
        wait_grant(g, t);
        req = 4'b1100;
        wait_grant(g, t);
        chk("arst_pre_grant", g, 4'b0100);
        for (int i = 0; i < 10; i++) begin
            if (tx_active && bit_idx == 2'd2) break;
            tick();
        end
        chk("arst_at_bit2", {tx_active, bit_idx}, {1'b1, 2'd2});
        #2;
        reset = 1'b1;
        #1;
        chk("arst_tx_active", tx_active, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_grant", grant, 4'b0000);
        chk("arst_load_n", piso_load_n, 1'b1);
        req = 4'b1010;
        @(negedge clk);
        reset = 1'b0;
        n0 = 0; t0a = 0; t0b = 0; g0a = '0; g0b = '0; tdut = -1; gdut = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant != 0 && tdut < 0) begin
                tdut = cyc;
                gdut = grant;
            end
            if (g0_grant != 0) begin
                if (n0 == 0) begin t0a = cyc; g0a = g0_grant; end
                else if (n0 == 1) begin t0b = cyc; g0b = g0_grant; end
                n0++;
            end
        end
        req = '0;
        chk("arst_first_grant", gdut, 4'b0010);
        chk("gap0_grant_count_ge2", (n0 >= 2), 1'b1);
        chk("gap0_first_grant", g0a, 4'b0010);
        chk("gap0_second_grant", g0b, 4'b1000);
        chk("gap0_spacing", t0b - t0a, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
